// File: rtl/cpu_pkg.sv
// Shared decode definitions: field positions, opcode/funct codes, ALU operation enum
// and the registered decode bundle handed to execute.
package cpu_pkg;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned NREGS   = 32;
    localparam int unsigned IMM_W   = 16;

    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_LSB = 11;
    localparam int unsigned SH_LSB = 6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_NOR = 4'd6,
        ALU_SLT = 4'd7,
        ALU_SLL = 4'd8,
        ALU_SRL = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic               op_valid;
        alu_op_t            alu_op;
        logic [XLEN-1:0]    rs_data;
        logic [XLEN-1:0]    rt_data;
        logic [XLEN-1:0]    imm_ext;
        logic               use_imm;
        logic [RADDR_W-1:0] dest_addr;
        logic               reg_write;
        logic               illegal;
    } id_bundle_t;
endpackage

// File: rtl/reg_file_32x32.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// register 0 hardwired to zero, whole array cleared by asynchronous reset.
module reg_file_32x32
    import cpu_pkg::*;
(
    input  logic               clka,
    input  logic               rst,
    input  logic [RADDR_W-1:0] ra_addr,
    input  logic [RADDR_W-1:0] rb_addr,
    output logic [XLEN-1:0]    ra_data_c,
    output logic [XLEN-1:0]    rb_data_c,
    input  logic               we,
    input  logic [RADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]    wdata
);
    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data_c = (ra_addr == '0) ? '0 : mem[ra_addr];
    assign rb_data_c = (rb_addr == '0) ? '0 : mem[rb_addr];
endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode stage: field decode, register read with write-back bypass,
// and a stall-able output register feeding execute.
module id_decode_stage
    import cpu_pkg::*;
(
    input  logic               clka,
    input  logic               rst,
    input  logic [XLEN-1:0]    Inst_code,
    input  logic               inst_valid,
    input  logic               stall,
    input  logic               wb_en,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic               op_valid,
    output alu_op_t            alu_op,
    output logic [XLEN-1:0]    rs_data,
    output logic [XLEN-1:0]    rt_data,
    output logic [XLEN-1:0]    imm_ext,
    output logic               use_imm,
    output logic [RADDR_W-1:0] dest_addr,
    output logic               reg_write,
    output logic               illegal
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [RADDR_W-1:0] rs, rt, rd, shamt;
    logic [IMM_W-1:0]   imm16;
    logic [XLEN-1:0]    rf_a, rf_b, rs_val, rt_val;
    logic               wb_live;
    id_bundle_t         d, q;

    assign opcode = Inst_code[OP_LSB +: 6];
    assign rs     = Inst_code[RS_LSB +: RADDR_W];
    assign rt     = Inst_code[RT_LSB +: RADDR_W];
    assign rd     = Inst_code[RD_LSB +: RADDR_W];
    assign shamt  = Inst_code[SH_LSB +: RADDR_W];
    assign funct  = Inst_code[5:0];
    assign imm16  = Inst_code[IMM_W-1:0];

    reg_file_32x32 u_rf (
        .clka      (clka),
        .rst       (rst),
        .ra_addr   (rs),
        .rb_addr   (rt),
        .ra_data_c (rf_a),
        .rb_data_c (rf_b),
        .we        (wb_en),
        .waddr     (wb_addr),
        .wdata     (wb_data)
    );

    // A write landing on this edge must be seen by the instruction captured on it.
    assign wb_live = wb_en && (wb_addr != '0);
    assign rs_val  = (wb_live && (wb_addr == rs)) ? wb_data : rf_a;
    assign rt_val  = (wb_live && (wb_addr == rt)) ? wb_data : rf_b;

    always_comb begin
        d          = '0;
        d.op_valid = 1'b1;
        d.alu_op   = ALU_NOP;
        d.rs_data  = rs_val;
        d.rt_data  = rt_val;
        if (opcode == OP_RTYPE) begin
            d.dest_addr = rd;
            case (funct)
                FN_ADD:  d.alu_op = ALU_ADD;
                FN_SUB:  d.alu_op = ALU_SUB;
                FN_AND:  d.alu_op = ALU_AND;
                FN_OR:   d.alu_op = ALU_OR;
                FN_XOR:  d.alu_op = ALU_XOR;
                FN_NOR:  d.alu_op = ALU_NOR;
                FN_SLT:  d.alu_op = ALU_SLT;
                FN_SLL, FN_SRL: begin
                    d.alu_op  = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
                    d.use_imm = 1'b1;
                    d.imm_ext = XLEN'(shamt);
                end
                default: d.illegal = 1'b1;
            endcase
        end else begin
            d.dest_addr = rt;
            d.use_imm   = 1'b1;
            case (opcode)
                OP_ADDI: begin d.alu_op = ALU_ADD; d.imm_ext = {{(XLEN-IMM_W){imm16[IMM_W-1]}}, imm16}; end
                OP_SLTI: begin d.alu_op = ALU_SLT; d.imm_ext = {{(XLEN-IMM_W){imm16[IMM_W-1]}}, imm16}; end
                OP_ANDI: begin d.alu_op = ALU_AND; d.imm_ext = XLEN'(imm16); end
                OP_ORI:  begin d.alu_op = ALU_OR;  d.imm_ext = XLEN'(imm16); end
                OP_XORI: begin d.alu_op = ALU_XOR; d.imm_ext = XLEN'(imm16); end
                OP_LUI:  begin d.alu_op = ALU_LUI; d.imm_ext = {imm16, {(XLEN-IMM_W){1'b0}}}; end
                default: begin d.illegal = 1'b1; d.use_imm = 1'b0; end
            endcase
        end
        d.reg_write = !d.illegal && (d.dest_addr != '0);
    end

    // Stall freezes the whole bundle; an empty slot only clears op_valid.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (!stall) begin
            if (inst_valid) begin
                q <= d;
            end else begin
                q.op_valid <= 1'b0;
            end
        end
    end

    assign op_valid  = q.op_valid;
    assign alu_op    = q.alu_op;
    assign rs_data   = q.rs_data;
    assign rt_data   = q.rt_data;
    assign imm_ext   = q.imm_ext;
    assign use_imm   = q.use_imm;
    assign dest_addr = q.dest_addr;
    assign reg_write = q.reg_write;
    assign illegal   = q.illegal;
endmodule

// File: tb/tb_id_decode_stage.sv
// Randomized bench for id_decode_stage against an instruction-level reference model,
// with directed literal checks on the key decode, bypass, stall and reset cases.
module tb_id_decode_stage;
    import cpu_pkg::*;

    logic        clka = 1'b0;
    logic        rst;
    logic [31:0] Inst_code;
    logic        inst_valid, stall, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        op_valid, use_imm, reg_write, illegal;
    alu_op_t     alu_op;
    logic [31:0] rs_data, rt_data, imm_ext;
    logic [4:0]  dest_addr;

    typedef struct packed {
        logic        ov;
        alu_op_t     alu;
        logic [31:0] rs, rt, imm;
        logic        ui;
        logic [4:0]  dest;
        logic        rw, ill;
    } exp_t;

    logic [31:0] rm [32];
    exp_t        exp_q;
    int          n_cmp = 0;
    int          n_err = 0;

    id_decode_stage dut (
        .clka(clka), .rst(rst), .Inst_code(Inst_code), .inst_valid(inst_valid),
        .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .op_valid(op_valid), .alu_op(alu_op), .rs_data(rs_data), .rt_data(rt_data),
        .imm_ext(imm_ext), .use_imm(use_imm), .dest_addr(dest_addr),
        .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clka = ~clka;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    // Register read as the instruction sees it on the capturing edge.
    function automatic logic [31:0] model_read(input int r);
        if (r == 0) return 32'h0;
        if (wb_en && (wb_addr != 0) && (int'(wb_addr) == r)) return wb_data;
        return rm[r];
    endfunction

    function automatic exp_t model_decode(input logic [31:0] ic);
        exp_t e;
        e = '0;
        e.ov = 1'b1;
        e.alu = ALU_NOP;
        e.rs = model_read(int'(ic[25:21]));
        e.rt = model_read(int'(ic[20:16]));
        if (ic[31:26] == 6'h00) begin
            e.dest = ic[15:11];
            case (ic[5:0])
                6'h20: e.alu = ALU_ADD;
                6'h22: e.alu = ALU_SUB;
                6'h24: e.alu = ALU_AND;
                6'h25: e.alu = ALU_OR;
                6'h26: e.alu = ALU_XOR;
                6'h27: e.alu = ALU_NOR;
                6'h2A: e.alu = ALU_SLT;
                6'h00: begin e.alu = ALU_SLL; e.ui = 1'b1; e.imm = {27'b0, ic[10:6]}; end
                6'h02: begin e.alu = ALU_SRL; e.ui = 1'b1; e.imm = {27'b0, ic[10:6]}; end
                default: e.ill = 1'b1;
            endcase
        end else begin
            e.dest = ic[20:16];
            e.ui = 1'b1;
            case (ic[31:26])
                6'h08: begin e.alu = ALU_ADD; e.imm = 32'($signed(ic[15:0])); end
                6'h0A: begin e.alu = ALU_SLT; e.imm = 32'($signed(ic[15:0])); end
                6'h0C: begin e.alu = ALU_AND; e.imm = {16'h0, ic[15:0]}; end
                6'h0D: begin e.alu = ALU_OR;  e.imm = {16'h0, ic[15:0]}; end
                6'h0E: begin e.alu = ALU_XOR; e.imm = {16'h0, ic[15:0]}; end
                6'h0F: begin e.alu = ALU_LUI; e.imm = {ic[15:0], 16'h0}; end
                default: begin e.ill = 1'b1; e.ui = 1'b0; end
            endcase
        end
        e.rw = !e.ill && (e.dest != 0);
        return e;
    endfunction

    task automatic compare();
        chk("op_valid", 32'(op_valid), 32'(exp_q.ov));
        if (exp_q.ov) begin
            chk("alu_op", 32'(alu_op), 32'(exp_q.alu));
            chk("rs_data", rs_data, exp_q.rs);
            chk("rt_data", rt_data, exp_q.rt);
            chk("reg_write", 32'(reg_write), 32'(exp_q.rw));
            chk("illegal", 32'(illegal), 32'(exp_q.ill));
            if (!exp_q.ill) begin
                chk("use_imm", 32'(use_imm), 32'(exp_q.ui));
                chk("dest_addr", 32'(dest_addr), 32'(exp_q.dest));
                if (exp_q.ui) chk("imm_ext", imm_ext, exp_q.imm);
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_op_valid"}, 32'(op_valid), 32'h0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'h0);
        chk({tag, "_rs_data"}, rs_data, 32'h0);
        chk({tag, "_rt_data"}, rt_data, 32'h0);
        chk({tag, "_imm_ext"}, imm_ext, 32'h0);
        chk({tag, "_use_imm"}, 32'(use_imm), 32'h0);
        chk({tag, "_dest_addr"}, 32'(dest_addr), 32'h0);
        chk({tag, "_reg_write"}, 32'(reg_write), 32'h0);
        chk({tag, "_illegal"}, 32'(illegal), 32'h0);
    endtask

    // One clock: predict from pre-edge inputs, advance the model, check after the edge.
    task automatic tick();
        exp_t nx;
        nx = exp_q;
        if (!stall) begin
            if (inst_valid) nx = model_decode(Inst_code);
            else nx.ov = 1'b0;
        end
        @(posedge clka);
        if (wb_en && (wb_addr != 0)) rm[wb_addr] = wb_data;
        exp_q = nx;
        #1;
        compare();
    endtask

    task automatic drive(input logic [31:0] ic, input logic iv, input logic st,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        Inst_code = ic; inst_valid = iv; stall = st;
        wb_en = we; wb_addr = wa; wb_data = wd;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] fns [9];
        logic [5:0] ops [6];
        logic [31:0] w;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
        ops = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
        w = $urandom;
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1, 2, 3: begin w[31:26] = 6'h00; w[5:0] = fns[$urandom_range(0, 8)]; end
            4, 5, 6, 7: w[31:26] = ops[$urandom_range(0, 5)];
            8:          begin w[31:26] = 6'h00; w[5:0] = 6'($urandom_range(0, 63)); end
            default:    ;
        endcase
        return w;
    endfunction

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(rand_inst(), ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 10),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
            tick();
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) rm[i] = 32'h0;
        exp_q = '0;
    endtask

    initial begin
        exp_t held;
        clear_model();
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        #22;
        chk_zero("reset");
        rst = 1'b0;

        // r3 = 0x1234, then add r1,r3,r3
        drive(32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_1234); tick();
        drive(32'h0063_0820, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); tick();
        chk("add_rs", rs_data, 32'h1234);
        chk("add_rt", rt_data, 32'h1234);
        chk("add_alu", 32'(alu_op), 32'(ALU_ADD));
        chk("add_dest", 32'(dest_addr), 32'd1);
        chk("add_rw", 32'(reg_write), 32'd1);

        // same-edge bypass into and r2,r3,r0
        drive(32'h0060_1024, 1'b1, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF); tick();
        chk("byp_rs", rs_data, 32'hDEAD_BEEF);
        chk("byp_rt", rt_data, 32'h0);
        chk("byp_alu", 32'(alu_op), 32'(ALU_AND));

        drive(32'h2004_FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); tick();
        chk("addi_imm", imm_ext, 32'hFFFF_FFFF);
        chk("addi_ui", 32'(use_imm), 32'd1);
        chk("addi_dest", 32'(dest_addr), 32'd4);
        drive(32'h3404_FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); tick();
        chk("ori_imm", imm_ext, 32'h0000_FFFF);

        // write to r0 is dropped
        drive(32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h55); tick();
        drive(32'h0000_0820, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); tick();
        chk("r0_rs", rs_data, 32'h0);
        chk("r0_rt", rt_data, 32'h0);

        drive(32'hFC00_0000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); tick();
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_rw", 32'(reg_write), 32'd0);
        chk("ill_alu", 32'(alu_op), 32'(ALU_NOP));
        chk("ill_ov", 32'(op_valid), 32'd1);

        // stall holds the bundle while a write still lands
        drive(32'h0063_0820, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); tick();
        held = exp_q;
        drive(32'h2004_0001, 1'b1, 1'b1, 1'b1, 5'd3, 32'h77); tick();
        drive(32'hFC00_0000, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        drive(32'h0000_0820, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0); tick();
        chk("stall_rs", rs_data, 32'hDEAD_BEEF);
        chk("stall_alu", 32'(alu_op), 32'(ALU_ADD));
        chk("stall_dest", 32'(dest_addr), 32'(held.dest));
        drive(32'h0063_0820, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); tick();
        chk("unstall_rs", rs_data, 32'h77);
        chk("unstall_ov", 32'(op_valid), 32'd1);

        drive(32'h0063_0820, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0); tick();
        chk("bubble_ov", 32'(op_valid), 32'd0);

        rand_cycles(3000);

        // asynchronous reset mid-run
        drive(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        #1;
        chk_zero("midrst");
        #100;
        clear_model();
        rst = 1'b0;
        drive(32'h00A0_0820, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0); tick();
        chk("r5_after_rst", rs_data, 32'h0);

        rand_cycles(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
